// File: rtl/qk_inst_sequencer.sv
// Q*K instruction sequencer: KLOAD -> GAP_A -> EXEC -> GAP_B -> MOVE -> [READ] -> DONE.
// Define SEQ_READBACK_EN to include the READ phase and the rd_valid/rd_idx readback outputs.
module qk_inst_sequencer #(
    parameter int NQ      = 8,
    parameter int COL     = 8,
    parameter int GAP_CYC = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    output logic [16:0] inst,
    output logic        busy,
    output logic        done,
    output logic [2:0]  phase,
    output logic        rd_valid,
    output logic [3:0]  rd_idx
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        KLOAD = 3'd1,
        GAP_A = 3'd2,
        EXEC  = 3'd3,
        GAP_B = 3'd4,
        MOVE  = 3'd5,
        READ  = 3'd6,
        DONE  = 3'd7
    } state_t;

    localparam logic [7:0] KLOAD_LAST = 8'(COL + 1);
    localparam logic [7:0] COL_LAST   = 8'(COL);
    localparam logic [7:0] Q_LAST     = 8'(NQ - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYC - 1);
    localparam state_t AFTER_KLOAD = (GAP_CYC != 0) ? GAP_A : EXEC;
    localparam state_t AFTER_EXEC  = (GAP_CYC != 0) ? GAP_B : MOVE;
`ifdef SEQ_READBACK_EN
    localparam state_t AFTER_MOVE  = READ;
`else
    localparam state_t AFTER_MOVE  = DONE;
`endif

    state_t      state, state_n;
    logic [7:0]  cnt, cnt_n;
    logic [16:0] inst_n;

    // Instruction word for a given state/cycle index; unnamed fields stay 0.
    function automatic logic [16:0] decode(input state_t s, input logic [7:0] c);
        logic [16:0] v;
        logic [7:0]  km1;
        v   = '0;
        km1 = c - 8'd1;
        case (s)
            KLOAD: begin
                v[6] = 1'b1;
                if (c != 8'd0 && c <= COL_LAST) begin
                    v[3]     = 1'b1;
                    v[15:12] = km1[3:0];
                end
            end
            EXEC: begin
                v[7]     = 1'b1;
                v[5]     = 1'b1;
                v[15:12] = c[3:0];
            end
            MOVE: begin
                v[16]   = 1'b1;
                v[0]    = 1'b1;
                v[11:8] = c[3:0];
            end
            READ: begin
                v[1]    = 1'b1;
                v[11:8] = c[3:0];
            end
            default: v = '0;
        endcase
        return v;
    endfunction

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 8'd1;
        case (state)
            IDLE: begin
                cnt_n = 8'd0;
                if (start) state_n = KLOAD;
            end
            KLOAD: if (cnt == KLOAD_LAST) begin state_n = AFTER_KLOAD; cnt_n = 8'd0; end
            GAP_A: if (cnt == GAP_LAST)   begin state_n = EXEC;        cnt_n = 8'd0; end
            EXEC:  if (cnt == Q_LAST)     begin state_n = AFTER_EXEC;  cnt_n = 8'd0; end
            GAP_B: if (cnt == GAP_LAST)   begin state_n = MOVE;        cnt_n = 8'd0; end
            MOVE:  if (cnt == Q_LAST)     begin state_n = AFTER_MOVE;  cnt_n = 8'd0; end
            READ:  if (cnt == Q_LAST)     begin state_n = DONE;        cnt_n = 8'd0; end
            DONE: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase
        if (abort && state != IDLE) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end
        // inst is decoded from the next state so it lines up with phase.
        inst_n = decode(state_n, cnt_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 8'd0;
            inst  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            inst  <= inst_n;
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign phase = state;

    // rd_valid is a one-cycle qualifier (no back-pressure): data on the
    // readback bus belongs to the pmem_rd issued in the previous cycle.
`ifdef SEQ_READBACK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid <= 1'b0;
            rd_idx   <= 4'd0;
        end else begin
            rd_valid <= (state == READ);
            if (state == READ) rd_idx <= cnt[3:0];
        end
    end
`else
    assign rd_valid = 1'b0;
    assign rd_idx   = 4'd0;
`endif

endmodule
